// File: rtl/move_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer_if
// Purpose  : Command/sensor inputs and PID-facing outputs of move_sequencer.
//            The abort signal exists only when MV_ABORT_EN is defined.
// Revision : 1.0
// ============================================================================
interface move_sequencer_if;
  logic        mv_vld;
  logic [11:0] mv_hdg;
  logic [2:0]  mv_sqrs;
  logic [11:0] heading;
  logic        heading_rdy;
  logic        cntrIR;
`ifdef MV_ABORT_EN
  logic        abort;
`endif
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic        busy;
  logic        mv_done;

  modport master (
    output mv_vld, mv_hdg, mv_sqrs, heading, heading_rdy, cntrIR,
`ifdef MV_ABORT_EN
    output abort,
`endif
    input  moving, err_vld, error, frwrd, busy, mv_done
  );

  modport slave (
    input  mv_vld, mv_hdg, mv_sqrs, heading, heading_rdy, cntrIR,
`ifdef MV_ABORT_EN
    input  abort,
`endif
    output moving, err_vld, error, frwrd, busy, mv_done
  );
endinterface
`default_nettype wire

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : move_sequencer
// Purpose  : Move-level controller: turn to heading, ramp up, count lines,
//            ramp down, pulse done. Optional abort input under MV_ABORT_EN.
// Revision : 1.0
// ============================================================================
module move_sequencer #(
  parameter logic [9:0]  RAMP_INC  = 10'h020,
  parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
  parameter logic [11:0] HDG_TOL   = 12'h02C
) (
  input  logic            clk,
  input  logic            rst,
  move_sequencer_if.slave mv_if
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TURN    = 3'd1,
    S_RAMP_UP = 3'd2,
    S_RAMP_DN = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] hdg_q, hdg_d;
  logic [3:0]  lines_tgt_q, lines_tgt_d;
  logic [3:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  frwrd_q, frwrd_d;
  logic [11:0] error_q, error_d;
  logic        err_vld_q, err_vld_d;
  logic        cntr_ir_q;
  logic        moving_q, moving_d;
  logic        busy_q, busy_d;
  logic        mv_done_q, mv_done_d;

  logic        w_line_rise;
  logic        w_abort;
  logic [11:0] w_err_neg;
  logic [11:0] w_err_abs;
  logic        w_err_in_tol;
  logic [10:0] w_frwrd_sum;
  logic [10:0] w_dec_amt;
  logic [9:0]  w_frwrd_up;
  logic [9:0]  w_frwrd_dn;

`ifdef MV_ABORT_EN
  assign w_abort = mv_if.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_line_rise = mv_if.cntrIR & ~cntr_ir_q;

  // The most negative error has no positive twin; clamp its magnitude.
  assign w_err_neg    = ~error_q + 12'd1;
  assign w_err_abs    = !error_q[11] ? error_q :
                        ((error_q == 12'h800) ? 12'h7FF : w_err_neg);
  assign w_err_in_tol = (w_err_abs < HDG_TOL);

  assign w_frwrd_sum = {1'b0, frwrd_q} + {1'b0, RAMP_INC};
  assign w_frwrd_up  = (w_frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : w_frwrd_sum[9:0];
  assign w_dec_amt   = {RAMP_INC, 1'b0};
  assign w_frwrd_dn  = ({1'b0, frwrd_q} > w_dec_amt) ? (frwrd_q - w_dec_amt[9:0]) : 10'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hdg_q       <= 12'd0;
      lines_tgt_q <= 4'd0;
      line_cnt_q  <= 4'd0;
      frwrd_q     <= 10'd0;
      error_q     <= 12'd0;
      err_vld_q   <= 1'b0;
      cntr_ir_q   <= 1'b0;
      moving_q    <= 1'b0;
      busy_q      <= 1'b0;
      mv_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdg_q       <= hdg_d;
      lines_tgt_q <= lines_tgt_d;
      line_cnt_q  <= line_cnt_d;
      frwrd_q     <= frwrd_d;
      error_q     <= error_d;
      err_vld_q   <= err_vld_d;
      cntr_ir_q   <= mv_if.cntrIR;
      moving_q    <= moving_d;
      busy_q      <= busy_d;
      mv_done_q   <= mv_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hdg_d       = hdg_q;
    lines_tgt_d = lines_tgt_q;
    line_cnt_d  = line_cnt_q;
    frwrd_d     = frwrd_q;
    error_d     = error_q;
    err_vld_d   = 1'b0;

    if ((state_q != S_IDLE) && mv_if.heading_rdy) begin
      err_vld_d = 1'b1;
      error_d   = mv_if.heading - hdg_q;
    end

    case (state_q)
      S_IDLE: begin
        if (mv_if.mv_vld) begin
          hdg_d       = mv_if.mv_hdg;
          lines_tgt_d = {mv_if.mv_sqrs, 1'b0};
          line_cnt_d  = 4'd0;
          frwrd_d     = 10'd0;
          state_d     = S_TURN;
        end
      end
      S_TURN: begin
        frwrd_d = 10'd0;
        if (w_abort) begin
          state_d = S_DONE;
        end else if (err_vld_q && w_err_in_tol) begin
          state_d = (lines_tgt_q != 4'd0) ? S_RAMP_UP : S_DONE;
        end
      end
      S_RAMP_UP: begin
        if (mv_if.heading_rdy) frwrd_d = w_frwrd_up;
        if (w_line_rise) line_cnt_d = line_cnt_q + 4'd1;
        // Deceleration starts once the last line is reached.
        if (w_abort || (line_cnt_q == (lines_tgt_q - 4'd1))) state_d = S_RAMP_DN;
      end
      S_RAMP_DN: begin
        if (mv_if.heading_rdy) frwrd_d = w_frwrd_dn;
        if (frwrd_q == 10'd0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    moving_d  = (state_d == S_TURN) || (state_d == S_RAMP_UP) || (state_d == S_RAMP_DN);
    busy_d    = (state_d != S_IDLE);
    mv_done_d = (state_d == S_DONE);
  end

  assign mv_if.moving  = moving_q;
  assign mv_if.err_vld = err_vld_q;
  assign mv_if.error   = error_q;
  assign mv_if.frwrd   = frwrd_q;
  assign mv_if.busy    = busy_q;
  assign mv_if.mv_done = mv_done_q;

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_sequencer
// Purpose  : Directed and randomized bench for move_sequencer with an
//            integer-arithmetic move model checked every cycle.
// Revision : 1.0
// ============================================================================
module tb_move_sequencer;
  localparam int P_INC = 32;
  localparam int P_MAX = 672;
  localparam int P_TOL = 44;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  move_sequencer_if bus ();

  move_sequencer #(
    .RAMP_INC (10'h020),
    .MAX_FRWRD(10'h2A0),
    .HDG_TOL  (12'h02C)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .mv_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 turning, 2 speeding up, 3 slowing down, 4 finished.
  int m_mode, m_hdg, m_tgt, m_cnt, m_frwrd, m_err;
  bit m_errv, m_prev_ir;

  task automatic model_step();
    int  nmode, old_frwrd, se, mag;
    bit  rise;
    if (rst) begin
      m_mode = 0; m_hdg = 0; m_tgt = 0; m_cnt = 0; m_frwrd = 0;
      m_err = 0; m_errv = 0; m_prev_ir = 0;
    end else begin
      nmode     = m_mode;
      old_frwrd = m_frwrd;
      rise      = bus.cntrIR && !m_prev_ir;
      se        = (m_err >= 2048) ? m_err - 4096 : m_err;
      mag       = (se < 0) ? -se : se;
      if (mag > 2047) mag = 2047;
      case (m_mode)
        0: if (bus.mv_vld) begin
             m_hdg = int'(bus.mv_hdg); m_tgt = int'(bus.mv_sqrs) * 2;
             m_cnt = 0; m_frwrd = 0; nmode = 1;
           end
        1: if (m_errv && mag < P_TOL) nmode = (m_tgt != 0) ? 2 : 4;
        2: begin
             if (bus.heading_rdy) m_frwrd = (m_frwrd + P_INC > P_MAX) ? P_MAX : m_frwrd + P_INC;
             if (m_cnt == m_tgt - 1) nmode = 3;
             if (rise) m_cnt++;
           end
        3: begin
             if (bus.heading_rdy) m_frwrd = (m_frwrd > 2 * P_INC) ? m_frwrd - 2 * P_INC : 0;
             if (old_frwrd == 0) nmode = 4;
           end
        default: nmode = 0;
      endcase
      if (m_mode != 0 && bus.heading_rdy) m_err = (int'(bus.heading) - m_hdg + 4096) % 4096;
      m_errv    = (m_mode != 0) && bus.heading_rdy;
      m_prev_ir = bus.cntrIR;
      m_mode    = nmode;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
      chk("moving",  bus.moving,  (m_mode >= 1 && m_mode <= 3));
      chk("busy",    bus.busy,    (m_mode != 0));
      chk("mv_done", bus.mv_done, (m_mode == 4));
      chk("err_vld", bus.err_vld, m_errv);
      chk("error",   bus.error,   m_err);
      chk("frwrd",   bus.frwrd,   m_frwrd);
    end
  end

  task automatic step(input logic hr, input logic [11:0] hd, input logic ir);
    bus.heading_rdy = hr;
    bus.heading     = hd;
    bus.cntrIR      = ir;
    @(negedge clk);
    bus.heading_rdy = 1'b0;
    bus.mv_vld      = 1'b0;
  endtask

  task automatic issue(input logic [11:0] h, input logic [2:0] s);
    bus.mv_vld  = 1'b1;
    bus.mv_hdg  = h;
    bus.mv_sqrs = s;
    @(negedge clk);
    bus.mv_vld  = 1'b0;
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int done_cnt;
    int n;
    done_cnt = 0;
    n = 0;
    while (bus.busy && n < budget) begin
      step(1'b1, 12'h000, 1'b0);
      if (bus.mv_done) done_cnt++;
      n++;
    end
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_idle"}, bus.busy, 1'b0);
  endtask

  logic [11:0] cmd_hdg;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.mv_vld = 1'b0; bus.mv_hdg = 12'h000; bus.mv_sqrs = 3'd0;
    bus.heading = 12'h000; bus.heading_rdy = 1'b0; bus.cntrIR = 1'b0;
`ifdef MV_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",   bus.busy,    1'b0);
    chk("rst_frwrd",  bus.frwrd,   10'h000);
    chk("rst_error",  bus.error,   12'h000);
    chk("rst_moving", bus.moving,  1'b0);
    @(negedge clk);

    // Turn: large error holds TURN, small error releases it.
    issue(12'h3FF, 3'd1);
    chk("turn_busy", bus.busy, 1'b1);
    step(1'b1, 12'h000, 1'b0);
    chk("turn_err_c01", bus.error, 12'hC01);
    chk("turn_errvld", bus.err_vld, 1'b1);
    repeat (3) step(1'b0, 12'h000, 1'b0);
    chk("turn_hold_moving", bus.moving, 1'b1);
    chk("turn_hold_frwrd", bus.frwrd, 10'h000);
    step(1'b1, 12'h3E0, 1'b0);
    chk("turn_err_fe1", bus.error, 12'hFE1);
    step(1'b0, 12'h3E0, 1'b0);
    step(1'b1, 12'h3E0, 1'b0);
    chk("ramp_first", bus.frwrd, 10'h020);
    repeat (29) step(1'b1, 12'h3E0, 1'b0);
    chk("ramp_sat", bus.frwrd, 10'h2A0);
    step(1'b0, 12'h3E0, 1'b1);
    step(1'b0, 12'h3E0, 1'b1);
    step(1'b1, 12'h3E0, 1'b0);
    chk("ramp_dn_1", bus.frwrd, 10'h260);
    step(1'b1, 12'h3E0, 1'b0);
    chk("ramp_dn_2", bus.frwrd, 10'h220);
    run_to_idle("ramp", 30);

    // Reset in the middle of a ramp.
    issue(12'h100, 3'd1);
    step(1'b1, 12'h100, 1'b0);
    step(1'b0, 12'h100, 1'b0);
    repeat (8) step(1'b1, 12'h100, 1'b0);
    chk("mid_frwrd_100", bus.frwrd, 10'h100);
    rst = 1'b1;
    #1;
    chk("mid_rst_frwrd",   bus.frwrd,   10'h000);
    chk("mid_rst_moving",  bus.moving,  1'b0);
    chk("mid_rst_busy",    bus.busy,    1'b0);
    chk("mid_rst_errvld",  bus.err_vld, 1'b0);
    chk("mid_rst_error",   bus.error,   12'h000);
    chk("mid_rst_done",    bus.mv_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", bus.busy, 1'b0);

    // Wrap-around error with zero squares: straight to DONE.
    issue(12'hFF0, 3'd0);
    step(1'b1, 12'h010, 1'b0);
    chk("wrap_err", bus.error, 12'h020);
    step(1'b0, 12'h010, 1'b0);
    chk("zero_done", bus.mv_done, 1'b1);
    chk("zero_frwrd", bus.frwrd, 10'h000);
    step(1'b0, 12'h010, 1'b0);
    chk("zero_idle", bus.busy, 1'b0);

    // A new command while busy must not disturb the latched heading.
    issue(12'h200, 3'd1);
    step(1'b1, 12'h200, 1'b0);
    step(1'b0, 12'h200, 1'b0);
    step(1'b1, 12'h200, 1'b0);
    step(1'b1, 12'h200, 1'b0);
    bus.mv_vld  = 1'b1;
    bus.mv_hdg  = 12'h555;
    bus.mv_sqrs = 3'd7;
    step(1'b1, 12'h210, 1'b0);
    chk("busy_hdg_kept", bus.error, 12'h010);
    chk("busy_frwrd", bus.frwrd, 10'h060);
    step(1'b0, 12'h210, 1'b1);
    step(1'b0, 12'h210, 1'b0);
    run_to_idle("busy", 30);

    // Randomized traffic; the per-cycle model does the checking.
    cmd_hdg = 12'h000;
    for (int i = 0; i < 4000; i++) begin
      bus.mv_vld = 1'b0;
      if ((!bus.busy && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0) begin
        bus.mv_vld  = 1'b1;
        bus.mv_hdg  = 12'($urandom);
        bus.mv_sqrs = 3'($urandom_range(0, 3));
        if (!bus.busy) cmd_hdg = bus.mv_hdg;
      end
      bus.heading_rdy = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) bus.heading = 12'($urandom);
      else bus.heading = cmd_hdg + 12'($urandom_range(0, 96)) - 12'd48;
      if ($urandom_range(0, 7) == 0) bus.cntrIR = ~bus.cntrIR;
      @(negedge clk);
    end
    bus.mv_vld = 1'b0;
    bus.heading_rdy = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/move_sequencer.md
# move_sequencer

Move-level controller that sequences the PID steering datapath of the Knight's Tour robot. It accepts one move command (desired heading plus square count) and first turns in place until heading error is within tolerance. It then ramps forward speed up, counts line crossings to track squares travelled, ramps down, and signals completion. Its outputs `moving`, `err_vld`, `error` and `frwrd` drive the PID block directly.

## Interface
Parameters:
- `RAMP_INC`, 10'h020: `frwrd` increment per `heading_rdy` during ramp-up; decrement is 2×RAMP_INC.
- `MAX_FRWRD`, 10'h2A0: saturation ceiling for `frwrd`.
- `HDG_TOL`, 12'h02C: turn-complete threshold on |error|.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mv_vld` in 1: one-cycle pulse; captures `mv_hdg` and `mv_sqrs`.
- `mv_hdg` in 12: desired heading.
- `mv_sqrs` in 3: squares to travel, 0–7.
- `heading` in 12: measured heading from inertial sensor.
- `heading_rdy` in 1: one-cycle pulse; `heading` is valid.
- `cntrIR` in 1: center IR line sensor, level; high while over a line.
- `abort` in 1: present only with `MV_ABORT_EN`.
- `moving` out 1: to PID; high in TURN, RAMP_UP, RAMP_DN.
- `err_vld` out 1: to PID.
- `error` out 12: to PID, signed.
- `frwrd` out 10: to PID, unsigned.
- `busy` out 1: high in any state other than IDLE.
- `mv_done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, TURN, RAMP_UP, RAMP_DN, DONE.
- IDLE:
  - `mv_vld` latches `hdg_reg`←`mv_hdg`, `lines_tgt`←{`mv_sqrs`,1'b0} (2 lines per square), clears the line counter and `frwrd`, then goes to TURN.
  - `mv_vld` in any other state is ignored.
- Error path, all states except IDLE:
  - On `heading_rdy`, `error`←`heading`−`hdg_reg`, modulo 2^12 (natural wrap, two's complement).
  - `err_vld` is a registered copy of `heading_rdy`.
  - In IDLE, `err_vld` is held 0.
- TURN:
  - `frwrd` held 0.
  - On a registered error sample (`err_vld`=1) with |error| < HDG_TOL, go to RAMP_UP if `lines_tgt`≠0, else go to DONE.
  - |error| of 12'h800 is treated as 12'h7FF.
- RAMP_UP:
  - On each `heading_rdy`, `frwrd`←min(`frwrd`+RAMP_INC, MAX_FRWRD), computed 11 bits wide and saturated.
  - Rising edges of `cntrIR` (one-flop edge detect) increment a 4-bit line counter.
  - When counter == `lines_tgt`−1, go to RAMP_DN, i.e. decelerate starting at the last line.
- RAMP_DN:
  - On each `heading_rdy`, `frwrd`←max(`frwrd`−2·RAMP_INC, 0), with no underflow.
  - When `frwrd`==0, go to DONE.
- DONE: `mv_done`=1 for exactly one cycle, `moving`=0, then IDLE.
- Simultaneous events:
  - A `cntrIR` edge in the same cycle as `heading_rdy` applies both.
  - A line edge in TURN is ignored; the counter only runs in RAMP_UP.

## Timing
- Reset values: `moving`=0, `err_vld`=0, `error`=0, `frwrd`=0, `busy`=0, `mv_done`=0; FSM in IDLE.
- `rst` asserted mid-move aborts immediately, asynchronously, to these values.
- Latency:
  - `mv_vld` → `busy`/`moving` high: 1 cycle.
  - `heading_rdy` → `err_vld`/`error`: 1 cycle.
  - `heading_rdy` → `frwrd` update: 1 cycle.
- All outputs are registered; no combinational input→output paths.
- The minimum move with `mv_sqrs`=0 and an in-tolerance first sample is IDLE→TURN→DONE→IDLE.

## Configuration
- `MV_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in TURN goes to DONE.
  - `abort`=1 in RAMP_UP goes to RAMP_DN.
  - `mv_done` still pulses once.
- `MV_ABORT_EN` undefined: the `abort` port is absent and moves always run to completion.

## Test plan
- Reset: assert `rst` mid-RAMP_UP with `frwrd`=10'h100 → all outputs 0 in the same cycle; `busy`=0 after release.
- Turn:
  - `mv_hdg`=12'h3FF, `heading`=12'h000 → `error`=12'hC01 and the FSM stays in TURN.
  - `heading`=12'h3E0 → `error`=12'hFE1 (|31| < 44) → RAMP_UP.
- Wrap: `mv_hdg`=12'hFF0, `heading`=12'h010 → `error`=12'h020 → TURN exits.
- Ramp and count:
  - `mv_sqrs`=1 with 30 `heading_rdy` pulses → `frwrd` saturates at 10'h2A0.
  - First `cntrIR` edge → RAMP_DN; `frwrd` drops 10'h040 per `heading_rdy`.
  - At 0, `mv_done` pulses once.
- Zero squares: `mv_sqrs`=0 with an in-tolerance heading → DONE without `frwrd` ever leaving 0.
- Busy: `mv_vld` during RAMP_UP with a new `mv_hdg` → `hdg_reg` unchanged and the move completes normally.
